// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing datapath: decoder state
// encoding, chunk-count helper and the default bitstream length.
package sc_pkg;

   localparam int SC_BSL = 255;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      HOLD  = 2'd2
   } sbs2bin_state_t;

   // Number of chunk-sized slices needed to cover a bsl-bit stream.
   function automatic int sc_num_chunks(input int bsl, input int chunk);
      return (bsl + chunk - 1) / chunk;
   endfunction

endpackage

// File: rtl/sbs_popcount.sv
// Combinational population count of one chunk of a stochastic bitstream.
module sbs_popcount #(
   parameter int chunk = 8
) (
   input  logic [chunk-1:0]           bits,
   output logic [$clog2(chunk+1)-1:0] count
);

   localparam int pop_width = $clog2(chunk + 1);

   always_comb begin
      count = '0;
      for (int i = 0; i < chunk; i++) begin
         count = count + pop_width'(bits[i]);
      end
   end

endmodule

// File: rtl/sbs2bin.sv
// Stochastic bitstream to binary decoder: captures a whole bitstream, counts
// its ones one chunk per cycle and returns the total over valid/ready.
module sbs2bin
   import sc_pkg::*;
#(
   parameter int bsl       = SC_BSL,
   parameter int chunk     = 8,
   parameter int cnt_width = $clog2(bsl + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [bsl-1:0]       a_sbs,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [cnt_width-1:0] a,
   output logic                 busy
);

   localparam int n_chunks   = sc_num_chunks(bsl, chunk);
   localparam int idx_width  = (n_chunks > 1) ? $clog2(n_chunks) : 1;
   localparam int pop_width  = $clog2(chunk + 1);
   localparam int full_width = n_chunks * chunk;

   sbs2bin_state_t          state_reg;
   sbs2bin_state_t          state_next;
   logic [full_width-1:0]   sbs_reg;
   logic [full_width-1:0]   sbs_padded;
   logic [idx_width-1:0]    idx_reg;
   logic [cnt_width-1:0]    acc_reg;
   logic [cnt_width-1:0]    acc_sum;
   logic [cnt_width-1:0]    a_reg;
   logic                    out_valid_reg;
   logic [chunk-1:0]        chunk_words [n_chunks];
   logic [chunk-1:0]        chunk_sel;
   logic [pop_width-1:0]    chunk_ones;
   logic                    accept;
   logic                    last_chunk;
   logic                    take;

   // Bits beyond bsl in the final chunk are held at zero so they never count.
   always_comb begin
      sbs_padded          = '0;
      sbs_padded[bsl-1:0] = a_sbs;
   end

   generate
      for (genvar gi = 0; gi < n_chunks; gi++) begin : g_chunk
         assign chunk_words[gi] = sbs_reg[gi*chunk +: chunk];
      end
   endgenerate

   assign chunk_sel = chunk_words[idx_reg];

   sbs_popcount #(
      .chunk(chunk)
   ) u_popcount (
      .bits (chunk_sel),
      .count(chunk_ones)
   );

   assign acc_sum    = acc_reg + cnt_width'(chunk_ones);
   assign last_chunk = (idx_reg == idx_width'(n_chunks - 1));
   assign accept     = (state_reg == IDLE) && in_valid;
   assign take       = out_valid_reg && out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (in_valid)   state_next = COUNT;
         COUNT:   if (last_chunk) state_next = HOLD;
         HOLD:    if (out_ready)  state_next = IDLE;
         default:                 state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready = 1'b0;
      busy     = 1'b0;
      case (state_reg)
         IDLE:    in_ready = 1'b1;
         COUNT:   busy     = 1'b1;
         HOLD:    busy     = 1'b1;
         default: in_ready = 1'b0;
      endcase
   end

   // The capture register needs no reset: it is only read after an accept.
   always_ff @(posedge clk) begin
      if (accept) begin
         sbs_reg <= sbs_padded;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_reg       <= '0;
         idx_reg       <= '0;
         a_reg         <= '0;
         out_valid_reg <= 1'b0;
      end else begin
         if (accept) begin
            acc_reg <= '0;
            idx_reg <= '0;
         end
         if (state_reg == COUNT) begin
            acc_reg <= acc_sum;
            idx_reg <= idx_reg + idx_width'(1);
            if (last_chunk) begin
               a_reg         <= acc_sum;
               out_valid_reg <= 1'b1;
            end
         end
         if (take) begin
            out_valid_reg <= 1'b0;
         end
      end
   end

   assign a         = a_reg;
   assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_sbs2bin.sv
// Randomized self-checking bench for sbs2bin: a scoreboard of ones-counts
// taken at each accept and compared at each output handshake.
module tb_sbs2bin;
   import sc_pkg::*;

   localparam int BSL     = SC_BSL;
   localparam int CHUNK   = 8;
   localparam int N_BIG   = (BSL + CHUNK - 1) / CHUNK;
   localparam int S_BSL   = 20;
   localparam int N_SMALL = (S_BSL + CHUNK - 1) / CHUNK;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [BSL-1:0]   a_sbs;
   logic             out_valid;
   logic             out_ready;
   logic [7:0]       a;
   logic             busy;

   logic             s_in_valid;
   logic             s_in_ready;
   logic [S_BSL-1:0] s_a_sbs;
   logic             s_out_valid;
   logic             s_out_ready;
   logic [4:0]       s_a;
   logic             s_busy;

   int n_checks = 0;
   int n_fails  = 0;
   int cyc      = 0;
   int exp_q[$];
   int acc_cyc[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sbs2bin #(.bsl(BSL), .chunk(CHUNK)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a_sbs(a_sbs), .out_valid(out_valid), .out_ready(out_ready),
      .a(a), .busy(busy)
   );

   sbs2bin #(.bsl(S_BSL), .chunk(CHUNK)) dut_small (
      .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .a_sbs(s_a_sbs), .out_valid(s_out_valid), .out_ready(s_out_ready),
      .a(s_a), .busy(s_busy)
   );

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [BSL-1:0] rand_vec(input int pct);
      logic [BSL-1:0] v;
      for (int i = 0; i < BSL; i++) v[i] = (int'($urandom_range(0, 99)) < pct);
      return v;
   endfunction

   // Reference model: each accepted stream's expected result is its ones-count.
   always @(negedge clk) begin
      int e;
      if (rst) begin
         exp_q.delete();
      end else begin
         if (in_valid && in_ready) begin
            exp_q.push_back($countones(a_sbs));
            acc_cyc.push_back(cyc);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check_eq("unexpected_output", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check_eq("frame_count", int'(a), e);
               $display("frame done at cycle %0d: a=%0d expected=%0d", cyc, a, e);
            end
         end
      end
   end

   task automatic send(input logic [BSL-1:0] vec, input int hold);
      int g;
      int lat;
      logic [7:0] a_hold;
      g = 0;
      while (!in_ready && g < 200) begin @(posedge clk); #1; g++; end
      check_eq("in_ready_before_accept", int'(in_ready), 1);
      a_sbs    = vec;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a_sbs    = rand_vec(50);
      check_eq("busy_in_count", int'(busy), 1);
      check_eq("in_ready_in_count", int'(in_ready), 0);
      lat = 0;
      while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
      check_eq("latency", lat, N_BIG);
      a_hold = a;
      for (int i = 0; i < hold; i++) begin
         in_valid = (i == hold / 2);
         a_sbs    = rand_vec(50);
         @(posedge clk); #1;
         check_eq("hold_a_stable", int'(a), int'(a_hold));
         check_eq("hold_in_ready", int'(in_ready), 0);
         check_eq("hold_out_valid", int'(out_valid), 1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check_eq("idle_in_ready", int'(in_ready), 1);
      check_eq("idle_out_valid", int'(out_valid), 0);
      check_eq("idle_busy", int'(busy), 0);
   endtask

   task automatic send_small(input logic [S_BSL-1:0] vec);
      int lat;
      int e;
      e          = $countones(vec);
      s_a_sbs    = vec;
      s_in_valid = 1'b1;
      @(posedge clk); #1;
      s_in_valid = 1'b0;
      s_a_sbs    = '0;
      lat = 0;
      while (!s_out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
      check_eq("small_latency", lat, N_SMALL);
      check_eq("small_count", int'(s_a), e);
      $display("small frame: a=%0d expected=%0d latency=%0d", s_a, e, lat);
      s_out_ready = 1'b1;
      @(posedge clk); #1;
      s_out_ready = 1'b0;
      check_eq("small_idle_valid", int'(s_out_valid), 0);
      check_eq("small_idle_ready", int'(s_in_ready), 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [BSL-1:0] v;
      int n0;
      int g;
      int sp;

      rst = 1'b1; in_valid = 1'b0; a_sbs = '0; out_ready = 1'b0;
      s_in_valid = 1'b0; s_a_sbs = '0; s_out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check_eq("reset_in_ready", int'(in_ready), 1);
      check_eq("reset_out_valid", int'(out_valid), 0);
      check_eq("reset_busy", int'(busy), 0);
      check_eq("reset_a", int'(a), 0);
      check_eq("reset_small_ready", int'(s_in_ready), 1);

      send('0, 0);
      send('1, 2);

      // Back-to-back with out_ready held high: alternating bits, then bit 254 only.
      for (int i = 0; i < BSL; i++) v[i] = (i % 2 == 0);
      out_ready = 1'b1;
      n0        = acc_cyc.size();
      a_sbs     = v;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      a_sbs      = '0;
      a_sbs[254] = 1'b1;
      g = 0;
      while (acc_cyc.size() < n0 + 2 && g < 200) begin @(posedge clk); #1; g++; end
      in_valid = 1'b0;
      check_eq("b2b_two_accepts", acc_cyc.size(), n0 + 2);
      if (acc_cyc.size() >= n0 + 2) begin
         sp = acc_cyc[n0 + 1] - acc_cyc[n0];
         check_eq("b2b_spacing_ok", int'(sp >= N_BIG + 1 && sp <= N_BIG + 2), 1);
      end
      g = 0;
      while (exp_q.size() != 0 && g < 200) begin @(posedge clk); #1; g++; end
      check_eq("b2b_drained", exp_q.size(), 0);
      @(posedge clk); #1;
      out_ready = 1'b0;

      send(rand_vec(40), 10);
      send(rand_vec(70), 1);
      for (int k = 0; k < 6; k++) begin
         send(rand_vec(int'($urandom_range(20, 100))), int'($urandom_range(0, 3)));
      end

      // Reset partway through COUNT discards the frame in flight.
      a_sbs    = '1;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_eq("midrst_busy", int'(busy), 0);
      check_eq("midrst_out_valid", int'(out_valid), 0);
      check_eq("midrst_a", int'(a), 0);
      check_eq("midrst_in_ready", int'(in_ready), 1);
      send('1, 0);

      send_small('1);
      send_small(S_BSL'($urandom));

      repeat (2) @(posedge clk);
      #1 check_eq("scoreboard_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
